sine_addr_gen: RTL and testbench

SINE_ADDR_GEN -- requirements
Module: sine_addr_gen

---
 rtl/sine_addr_gen.sv | 128 ++++++++++++
 tb/tb_sine_addr_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_addr_gen.sv
// Phase-accumulator address generator for a sine sample ROM.
// Issues ROM addresses, counts wraps, and flags samples one cycle later.
module sine_addr_gen #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int INCR_WIDTH    = 8,
  parameter int WRAP_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     en,
  input  logic                     continuous,
  input  logic [ADDRESS_WIDTH-1:0] start_addr,
  input  logic [INCR_WIDTH-1:0]    incr,
  input  logic [WRAP_WIDTH-1:0]    num_wraps,
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic                     addr_vld,
  output logic                     sample_valid,
  output logic                     wrap,
  output logic                     done,
  output logic                     busy
);

  localparam int SW = ADDRESS_WIDTH + 1;
  localparam int CW = WRAP_WIDTH + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [INCR_WIDTH-1:0]   incr_q, incr_d;
  logic [WRAP_WIDTH-1:0]   wcnt_q, wcnt_d;
  logic [WRAP_WIDTH-1:0]   nw_q, nw_d;
  logic                    vld_q, vld_d;
  logic                    sv_q, sv_d;
  logic                    wrap_q, wrap_d;
  logic                    done_q, done_d;

  logic [SW-1:0] sum;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] tgt;
  logic          carry;

  always_comb begin
    sum     = {1'b0, addr_q} + SW'(incr_q);
    carry   = sum[SW-1];
    cnt_nxt = {1'b0, wcnt_q} + CW'(1);
    // zero wraps requested behaves like one
    tgt     = (nw_q == '0) ? CW'(1) : {1'b0, nw_q};

    state_d = state_q;
    addr_d  = addr_q;
    incr_d  = incr_q;
    wcnt_d  = wcnt_q;
    nw_d    = nw_q;
    vld_d   = 1'b0;
    sv_d    = vld_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop && incr != '0) begin
          state_d = RUN;
          addr_d  = start_addr;
          incr_d  = incr;
          nw_d    = num_wraps;
          wcnt_d  = '0;
          vld_d   = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (en) begin
          if (carry) begin
            wrap_d = 1'b1;
            if (wcnt_q != '1) wcnt_d = cnt_nxt[WRAP_WIDTH-1:0];
            if (!continuous && cnt_nxt >= tgt) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              addr_d = sum[ADDRESS_WIDTH-1:0];
              vld_d  = 1'b1;
            end
          end else begin
            addr_d = sum[ADDRESS_WIDTH-1:0];
            vld_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      incr_q  <= '0;
      wcnt_q  <= '0;
      nw_q    <= '0;
      vld_q   <= 1'b0;
      sv_q    <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      incr_q  <= incr_d;
      wcnt_q  <= wcnt_d;
      nw_q    <= nw_d;
      vld_q   <= vld_d;
      sv_q    <= sv_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign addr         = addr_q;
  assign addr_vld     = vld_q;
  assign sample_valid = sv_q;
  assign wrap         = wrap_q;
  assign done         = done_q;
  assign busy         = (state_q == RUN);

endmodule

// File: tb/tb_sine_addr_gen.sv
// Bench for sine_addr_gen: arithmetic reference model checked every
// cycle, plus directed sequences with literal expectations.
module tb_sine_addr_gen;

  localparam int AW = 8;
  localparam int IW = 8;
  localparam int WW = 8;

  logic          clk = 0;
  logic          reset = 0;
  logic          start = 0;
  logic          stop = 0;
  logic          en = 0;
  logic          continuous = 0;
  logic [AW-1:0] start_addr = '0;
  logic [IW-1:0] incr = '0;
  logic [WW-1:0] num_wraps = '0;
  logic [AW-1:0] addr;
  logic          addr_vld, sample_valid, wrap, done, busy;

  int checks = 0;
  int failures = 0;
  bit mon = 0;
  bit seen_done;

  always #5 clk = ~clk;

  sine_addr_gen #(
    .ADDRESS_WIDTH(AW),
    .INCR_WIDTH(IW),
    .WRAP_WIDTH(WW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .en(en),
    .continuous(continuous),
    .start_addr(start_addr),
    .incr(incr),
    .num_wraps(num_wraps),
    .addr(addr),
    .addr_vld(addr_vld),
    .sample_valid(sample_valid),
    .wrap(wrap),
    .done(done),
    .busy(busy)
  );

  typedef struct packed {
    bit run;
    int a;
    int inc;
    int cnt;
    int nw;
    bit vld;
    bit sv;
    bit wr;
    bit dn;
  } mst_t;

  mst_t ms = '0;

  function automatic mst_t nxt(mst_t m, bit st, bit sp, bit e, bit c,
                               int sa, int inc, int nw);
    mst_t r;
    int s;
    int goal;
    r     = m;
    r.sv  = m.vld;
    r.vld = 0;
    r.wr  = 0;
    r.dn  = 0;
    if (!m.run) begin
      if (st && !sp && inc != 0) begin
        r.run = 1; r.a = sa; r.inc = inc; r.nw = nw; r.cnt = 0; r.vld = 1;
      end
    end else if (sp) begin
      r.run = 0;
    end else if (e) begin
      s = m.a + m.inc;
      if (s >= (1 << AW)) begin
        r.wr = 1;
        goal = (m.nw == 0) ? 1 : m.nw;
        if (!c && m.cnt + 1 >= goal) begin
          r.run = 0; r.dn = 1;
        end else begin
          r.a = s - (1 << AW); r.vld = 1;
        end
        r.cnt = (m.cnt + 1 > (1 << WW) - 1) ? (1 << WW) - 1 : m.cnt + 1;
      end else begin
        r.a = s; r.vld = 1;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) ms <= '0;
    else ms <= nxt(ms, start, stop, en, continuous,
                   int'(start_addr), int'(incr), int'(num_wraps));
  end

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon) begin
      chk("m_addr", int'(addr), ms.a);
      chk("m_vld", int'(addr_vld), int'(ms.vld));
      chk("m_sv", int'(sample_valid), int'(ms.sv));
      chk("m_wrap", int'(wrap), int'(ms.wr));
      chk("m_done", int'(done), int'(ms.dn));
      chk("m_busy", int'(busy), int'(ms.run));
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_addr", int'(addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_vld", int'(addr_vld), 0);
    reset = 1;
    mon = 1;
    cyc();

    // continuous wrap
    start_addr = 8'hF0; incr = 8'h08; continuous = 1; en = 1; start = 1;
    cyc(); start = 0;
    chk("c_a0", int'(addr), 'hF0);
    chk("c_v0", int'(addr_vld), 1);
    chk("c_sv0", int'(sample_valid), 0);
    cyc();
    chk("c_a1", int'(addr), 'hF8);
    chk("c_w1", int'(wrap), 0);
    chk("c_sv1", int'(sample_valid), 1);
    cyc();
    chk("c_a2", int'(addr), 'h00);
    chk("c_w2", int'(wrap), 1);
    cyc();
    chk("c_a3", int'(addr), 'h08);
    chk("c_w3", int'(wrap), 0);
    stop = 1; cyc(); stop = 0;
    chk("c_stop_busy", int'(busy), 0);
    chk("c_stop_addr", int'(addr), 'h08);

    // single shot, two wraps
    start_addr = 8'h00; incr = 8'h80; num_wraps = 2; continuous = 0;
    start = 1; cyc(); start = 0;
    chk("s_a0", int'(addr), 'h00);
    cyc(); chk("s_a1", int'(addr), 'h80);
    cyc();
    chk("s_a2", int'(addr), 'h00);
    chk("s_w2", int'(wrap), 1);
    chk("s_d2", int'(done), 0);
    cyc(); chk("s_a3", int'(addr), 'h80);
    cyc();
    chk("s_w4", int'(wrap), 1);
    chk("s_d4", int'(done), 1);
    chk("s_b4", int'(busy), 0);
    chk("s_a4", int'(addr), 'h80);
    chk("s_v4", int'(addr_vld), 0);
    cyc();
    chk("s_w5", int'(wrap), 0);
    chk("s_d5", int'(done), 0);

    // enable gap
    start_addr = 8'h0E; incr = 8'h01; continuous = 1; en = 1;
    start = 1; cyc(); start = 0;
    cyc(); cyc();
    chk("g_a", int'(addr), 'h10);
    en = 0;
    cyc();
    chk("g_a0", int'(addr), 'h10);
    chk("g_v0", int'(addr_vld), 0);
    chk("g_sv0", int'(sample_valid), 1);
    cyc();
    chk("g_sv1", int'(sample_valid), 0);
    cyc();
    chk("g_a2", int'(addr), 'h10);
    en = 1; cyc();
    chk("g_a3", int'(addr), 'h11);
    chk("g_v3", int'(addr_vld), 1);
    stop = 1; cyc(); stop = 0;

    // stop on the carry cycle
    start_addr = 8'hFE; incr = 8'h01; num_wraps = 1; continuous = 0;
    start = 1; cyc(); start = 0;
    cyc(); chk("p_a", int'(addr), 'hFF);
    stop = 1; cyc(); stop = 0;
    chk("p_busy", int'(busy), 0);
    chk("p_addr", int'(addr), 'hFF);
    chk("p_wrap", int'(wrap), 0);
    chk("p_done", int'(done), 0);

    // illegal starts
    incr = 8'h00; start = 1; cyc();
    chk("i0_busy", int'(busy), 0);
    chk("i0_addr", int'(addr), 'hFF);
    incr = 8'h05; stop = 1; cyc();
    chk("i1_busy", int'(busy), 0);
    chk("i1_addr", int'(addr), 'hFF);
    start = 0; stop = 0;

    // en pattern sweep, then switch to single shot with num_wraps=0
    start_addr = 8'h03; incr = 8'h37; num_wraps = 0; continuous = 1;
    start = 1; cyc(); start = 0;
    incr = 8'h01; start_addr = 8'h00;
    for (int i = 0; i < 40; i++) begin
      en = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      cyc();
    end
    start = 0; en = 1; continuous = 0;
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (done) seen_done = 1;
    end
    chk("r_done_seen", int'(seen_done), 1);
    chk("r_busy", int'(busy), 0);

    // wrap counter saturation in free-run
    start_addr = 8'h00; incr = 8'h80; num_wraps = 8'hFF; continuous = 1;
    start = 1; cyc(); start = 0;
    repeat (600) cyc();
    continuous = 0;
    seen_done = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (done) seen_done = 1;
    end
    chk("sat_done", int'(seen_done), 1);

    // asynchronous reset mid-sweep
    start_addr = 8'h20; incr = 8'h04; continuous = 1; en = 1;
    start = 1; cyc(); start = 0;
    cyc(); cyc();
    chk("a_busy_pre", int'(busy), 1);
    @(posedge clk);
    #2 reset = 0;
    #1;
    chk("a_addr", int'(addr), 0);
    chk("a_vld", int'(addr_vld), 0);
    chk("a_sv", int'(sample_valid), 0);
    chk("a_wrap", int'(wrap), 0);
    chk("a_done", int'(done), 0);
    chk("a_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1;
    cyc();
    chk("a_idle_addr", int'(addr), 0);
    chk("a_idle_busy", int'(busy), 0);
    cyc();
    chk("a_idle_done", int'(done), 0);

    mon = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
